pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Next-gen hazard unit for the 5-stage MIPS core (F/D/E/M/W): EX/D forwarding, load-use/mfc0/branch/jump
//  stalls, plus owned sequential control: internal divider busy FSM, bus-stall arbitration and a deferred
//  exception flush that waits for outstanding SRAM-like bus transfers. Sits beside datapath; drives all stall/flush.
// PARAMETERS
//  REG_AW     5   register-address width
//  DIV_CYCLES 34  cycles a divide occupies E (>=2)
//  CNT_W      32  perf counter width (only with HAZARD_PERF_CNT_EN)
// PORTS
//  clk          in  1       core clock
//  resetn       in  1       asynchronous, active-low reset
//  rs_d,rt_d,rs_e,rt_e  in REG_AW  source regs in D/E
//  wreg_e,wreg_m,wreg_w in REG_AW  dest regs; wen_e,wen_m,wen_w in 1 write enables
//  mem_to_reg_e/_m, cp0_to_reg_e/_m in 1   load / mfc0 in E,M
//  branch_d,jump_d in 1; hilo_read_e,hilo_wen_m in 1; div_start_e in 1 (div/divu in E)
//  inst_busy,data_busy in 1  bus transfer outstanding
//  exc_m        in  1       exception/eret committed in M
//  fwd_a_e,fwd_b_e out 2    10=from M, 01=from W, 00=regfile
//  fwd_a_d,fwd_b_d,fwd_hilo out 1
//  stall_f,stall_d,stall_e,stall_m,stall_w out 1
//  flush_d,flush_e,flush_m,flush_w out 1
//  div_done     out 1       one-cycle pulse: divider result valid in E
// BEHAVIOUR
//  - All flops async-cleared on resetn=0; outputs gated to 0 while resetn=0. Reg 0 never forwards/stalls.
//  - Fwd E: M priority over W; needs wen and reg match. fwd_a_d/b_d from M only. fwd_hilo=hilo_read_e&hilo_wen_m.
//  - lu = (mem_to_reg_e|cp0_to_reg_e)&wen_e&(rt_e==rs_d|rt_e==rt_d). br = branch_d & (E writes rs_d/rt_d, or
//    load/mfc0 in M writes them). jp = jump_d, same on rs_d only. dstall = lu|br|jp.
//  - Div FSM IDLE/BUSY/DONE, counter $clog2(DIV_CYCLES) bits:
//    IDLE & div_start_e & ~flush -> BUSY, cnt=DIV_CYCLES-2; BUSY: cnt-- ; cnt==0 -> DONE; DONE -> IDLE always
//    (div_start_e still high in DONE must not restart). div_stall = BUSY | (IDLE & div_start_e). div_done=DONE.
//    Total E occupancy = DIV_CYCLES cycles. Bus stall freezes cnt (no decrement while bstall).
//  - bstall = inst_busy|data_busy.
//  - Flush: exc_m & ~bstall -> flush_d/e/m/w=1 same cycle. exc_m & bstall -> set flush_pend; flush outputs
//    fire the first cycle bstall=0, pend clears. New exc_m while pend: absorbed (single flush).
//    Any flush forces div FSM->IDLE next edge, overrides all stalls (stall_*=0 that cycle).
//  - Else: stall_f=stall_d = dstall|div_stall|bstall|flush_pend; stall_e/m/w = div_stall|bstall|flush_pend;
//    flush_e = dstall & ~bstall & ~div_stall (bubble only when E advances); flush_d/m/w=0.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds outputs perf_lu_cnt, perf_br_cnt, perf_div_cnt, perf_bus_cnt [CNT_W-1:0],
//  saturating counts of cycles each stall cause asserted (several may count one cycle); cleared by reset only.
//  Undefined: ports and counters absent; other behaviour identical.
// STRUCTURE
//  Shared pkg/header (hazard_defs): FWD_NONE=2'b00, FWD_W=2'b01, FWD_M=2'b10; DIV_IDLE/BUSY/DONE encodings.
//  One sub-module: hazard_div_fsm (FSM+counter, ports clk,resetn,start,hold,abort -> stall,done).
//  Top holds forwarding/stall logic, flush_pend flop and perf counters.
// TESTING
//  1 rs_e=3,wreg_m=3,wen_m=1 and wreg_w=3,wen_w=1 -> fwd_a_e=10; clear wen_m -> 01; rs_e=0 -> 00.
//  2 load in E rt_e=5, rs_d=5 -> stall_f/d=1, flush_e=1 one cycle; next cycle clear.
//  3 div_start_e held, DIV_CYCLES=34 -> stall_e high 33 cycles, div_done pulse cycle 34, no restart.
//  4 inst_busy=1 for 4 cycles during div BUSY -> completion delayed exactly 4 cycles.
//  5 exc_m with data_busy=1 3 cycles -> no flush for 3 cycles, flush_d..w=1 on 4th, div FSM->IDLE.
//  6 resetn low mid-BUSY and with flush_pend -> all outputs 0; after release, no stale flush/div_done.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared hazard-unit definitions: forwarding select codes and divider FSM state encodings.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } divState_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard unit bundle; master is the datapath side, slave is the hazard unit.
interface pipe_hazard_ctrl_if #(parameter int REG_AW = 5);

    logic [REG_AW-1:0] rs_d, rt_d, rs_e, rt_e;
    logic [REG_AW-1:0] wreg_e, wreg_m, wreg_w;
    logic wen_e, wen_m, wen_w;
    logic mem_to_reg_e, mem_to_reg_m, cp0_to_reg_e, cp0_to_reg_m;
    logic branch_d, jump_d, hilo_read_e, hilo_wen_m, div_start_e;
    logic inst_busy, data_busy, exc_m;

    logic [1:0] fwd_a_e, fwd_b_e;
    logic fwd_a_d, fwd_b_d, fwd_hilo;
    logic stall_f, stall_d, stall_e, stall_m, stall_w;
    logic flush_d, flush_e, flush_m, flush_w;
    logic div_done;

    modport master (
        output rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w, wen_e, wen_m, wen_w,
               mem_to_reg_e, mem_to_reg_m, cp0_to_reg_e, cp0_to_reg_m,
               branch_d, jump_d, hilo_read_e, hilo_wen_m, div_start_e,
               inst_busy, data_busy, exc_m,
        input  fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, fwd_hilo,
               stall_f, stall_d, stall_e, stall_m, stall_w,
               flush_d, flush_e, flush_m, flush_w, div_done
    );

    modport slave (
        input  rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w, wen_e, wen_m, wen_w,
               mem_to_reg_e, mem_to_reg_m, cp0_to_reg_e, cp0_to_reg_m,
               branch_d, jump_d, hilo_read_e, hilo_wen_m, div_start_e,
               inst_busy, data_busy, exc_m,
        output fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, fwd_hilo,
               stall_f, stall_d, stall_e, stall_m, stall_w,
               flush_d, flush_e, flush_m, flush_w, div_done
    );

endinterface

// File: rtl/pipe_hazard_ctrl_div_fsm.sv
// Divider occupancy tracker: holds E for DIV_CYCLES cycles, freezes under hold, drops on abort.
//
//  state    | meaning
//  DIV_IDLE | no divide in flight; a start request stalls this cycle and launches
//  DIV_BUSY | counting down the remaining occupancy cycles
//  DIV_DONE | one-cycle result-valid pulse, always returns to idle
module hazard_div_fsm
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 34
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic hold,
    input  logic abort,
    output logic stall,
    output logic done
);

    localparam int CW = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0] LOAD = CW'(DIV_CYCLES - 2);

    divState_t state, stateNext;
    logic [CW-1:0] cnt, cntNext;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= DIV_IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Launch-cycle plus DIV_CYCLES-2 busy cycles plus the done cycle gives the full occupancy.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        if (abort) begin
            stateNext = DIV_IDLE;
            cntNext   = '0;
        end else begin
            case (state)
                DIV_IDLE: if (start) begin
                    cntNext   = LOAD;
                    stateNext = (LOAD == '0) ? DIV_DONE : DIV_BUSY;
                end
                DIV_BUSY: if (!hold) begin
                    cntNext = cnt - 1'b1;
                    if (cnt == CW'(1)) stateNext = DIV_DONE;
                end
                DIV_DONE: stateNext = DIV_IDLE;
                default:  stateNext = DIV_IDLE;
            endcase
        end
    end

    always_comb begin
        stall = (state == DIV_BUSY) || ((state == DIV_IDLE) && start);
        done  = (state == DIV_DONE);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard unit for the 5-stage core: forwarding, data/control stalls, divider and bus stalls, deferred flush.
// HAZARD_PERF_CNT_EN adds saturating stall-cause cycle counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int DIV_CYCLES = 34
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W      = 32
`endif
) (
    input  logic clk,
    input  logic resetn,
    pipe_hazard_ctrl_if.slave hif
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_W-1:0] perf_lu_cnt,
    output logic [CNT_W-1:0] perf_br_cnt,
    output logic [CNT_W-1:0] perf_div_cnt,
    output logic [CNT_W-1:0] perf_bus_cnt
`endif
);

    function automatic logic regHit(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] dst,
                                    input logic wen);
        return wen && (dst != '0) && (dst == src);
    endfunction

    function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src,
                                          input logic [REG_AW-1:0] dstM, input logic wenM,
                                          input logic [REG_AW-1:0] dstW, input logic wenW);
        if (regHit(src, dstM, wenM)) return FWD_M;
        if (regHit(src, dstW, wenW)) return FWD_W;
        return FWD_NONE;
    endfunction

    logic isLoadE, isLoadM, eHitRs, eHitRt, mHitRs, mHitRt;
    logic luHaz, brHaz, jpHaz, dStall, bStall;
    logic divStall, divDone, flushNow, flushPend, hold;

    assign isLoadE = hif.mem_to_reg_e | hif.cp0_to_reg_e;
    assign isLoadM = hif.mem_to_reg_m | hif.cp0_to_reg_m;
    assign eHitRs  = regHit(hif.rs_d, hif.wreg_e, hif.wen_e);
    assign eHitRt  = regHit(hif.rt_d, hif.wreg_e, hif.wen_e);
    assign mHitRs  = isLoadM & regHit(hif.rs_d, hif.wreg_m, hif.wen_m);
    assign mHitRt  = isLoadM & regHit(hif.rt_d, hif.wreg_m, hif.wen_m);

    assign luHaz  = isLoadE & (regHit(hif.rs_d, hif.rt_e, hif.wen_e) | regHit(hif.rt_d, hif.rt_e, hif.wen_e));
    assign brHaz  = hif.branch_d & (eHitRs | eHitRt | mHitRs | mHitRt);
    assign jpHaz  = hif.jump_d & (eHitRs | mHitRs);
    assign dStall = luHaz | brHaz | jpHaz;
    assign bStall = hif.inst_busy | hif.data_busy;

    // A flush can only fire once no bus transfer is outstanding; pending ones wait here.
    assign flushNow = (hif.exc_m | flushPend) & ~bStall;
    assign hold     = bStall;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                    flushPend <= 1'b0;
        else if (flushNow)              flushPend <= 1'b0;
        else if (hif.exc_m && bStall)   flushPend <= 1'b1;
    end

    hazard_div_fsm #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk    (clk),
        .resetn (resetn),
        .start  (hif.div_start_e),
        .hold   (hold),
        .abort  (flushNow),
        .stall  (divStall),
        .done   (divDone)
    );

    always_comb begin
        hif.fwd_a_e  = FWD_NONE;
        hif.fwd_b_e  = FWD_NONE;
        hif.fwd_a_d  = 1'b0;
        hif.fwd_b_d  = 1'b0;
        hif.fwd_hilo = 1'b0;
        hif.stall_f  = 1'b0;
        hif.stall_d  = 1'b0;
        hif.stall_e  = 1'b0;
        hif.stall_m  = 1'b0;
        hif.stall_w  = 1'b0;
        hif.flush_d  = 1'b0;
        hif.flush_e  = 1'b0;
        hif.flush_m  = 1'b0;
        hif.flush_w  = 1'b0;
        hif.div_done = 1'b0;
        if (resetn) begin
            hif.fwd_a_e  = fwdSel(hif.rs_e, hif.wreg_m, hif.wen_m, hif.wreg_w, hif.wen_w);
            hif.fwd_b_e  = fwdSel(hif.rt_e, hif.wreg_m, hif.wen_m, hif.wreg_w, hif.wen_w);
            hif.fwd_a_d  = regHit(hif.rs_d, hif.wreg_m, hif.wen_m);
            hif.fwd_b_d  = regHit(hif.rt_d, hif.wreg_m, hif.wen_m);
            hif.fwd_hilo = hif.hilo_read_e & hif.hilo_wen_m;
            hif.div_done = divDone;
            if (flushNow) begin
                hif.flush_d = 1'b1;
                hif.flush_e = 1'b1;
                hif.flush_m = 1'b1;
                hif.flush_w = 1'b1;
            end else begin
                hif.stall_f = dStall | divStall | bStall | flushPend;
                hif.stall_d = dStall | divStall | bStall | flushPend;
                hif.stall_e = divStall | bStall | flushPend;
                hif.stall_m = divStall | bStall | flushPend;
                hif.stall_w = divStall | bStall | flushPend;
                hif.flush_e = dStall & ~bStall & ~divStall;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_lu_cnt  <= '0;
            perf_br_cnt  <= '0;
            perf_div_cnt <= '0;
            perf_bus_cnt <= '0;
        end else begin
            if (luHaz && (perf_lu_cnt != '1))             perf_lu_cnt  <= perf_lu_cnt + 1'b1;
            if ((brHaz || jpHaz) && (perf_br_cnt != '1))  perf_br_cnt  <= perf_br_cnt + 1'b1;
            if (divStall && (perf_div_cnt != '1))         perf_div_cnt <= perf_div_cnt + 1'b1;
            if (bStall && (perf_bus_cnt != '1))           perf_bus_cnt <= perf_bus_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

    localparam int DIV_CYCLES = 34;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int nChecks = 0;
    int nErrors = 0;

    // reference model state: busy cycles still owed, done pulse due, flush waiting on the bus
    int mRem = 0;
    bit mDone = 0;
    bit mPend = 0;
    bit mFlush = 0;

    pipe_hazard_ctrl_if #(.REG_AW(5)) hif ();

    pipe_hazard_ctrl #(.REG_AW(5), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk    (clk),
        .resetn (resetn),
        .hif    (hif)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [16:0] outVec();
        return {hif.fwd_a_e, hif.fwd_b_e, hif.fwd_a_d, hif.fwd_b_d, hif.fwd_hilo,
                hif.stall_f, hif.stall_d, hif.stall_e, hif.stall_m, hif.stall_w,
                hif.flush_d, hif.flush_e, hif.flush_m, hif.flush_w, hif.div_done};
    endfunction

    function automatic bit hit(input logic [4:0] src, input logic [4:0] dst, input logic wen);
        return (wen == 1'b1) && (dst != 5'd0) && (dst == src);
    endfunction

    function automatic logic [1:0] fwdE(input logic [4:0] src);
        if (hit(src, hif.wreg_m, hif.wen_m)) return 2'd2;
        if (hit(src, hif.wreg_w, hif.wen_w)) return 2'd1;
        return 2'd0;
    endfunction

    task automatic clearInputs();
        hif.rs_d = 0; hif.rt_d = 0; hif.rs_e = 0; hif.rt_e = 0;
        hif.wreg_e = 0; hif.wreg_m = 0; hif.wreg_w = 0;
        hif.wen_e = 0; hif.wen_m = 0; hif.wen_w = 0;
        hif.mem_to_reg_e = 0; hif.mem_to_reg_m = 0; hif.cp0_to_reg_e = 0; hif.cp0_to_reg_m = 0;
        hif.branch_d = 0; hif.jump_d = 0; hif.hilo_read_e = 0; hif.hilo_wen_m = 0;
        hif.div_start_e = 0; hif.inst_busy = 0; hif.data_busy = 0; hif.exc_m = 0;
    endtask

    // Wait for the falling edge, predict every output from the current inputs and model state, compare.
    task automatic settle();
        logic [16:0] e;
        bit bst, divSt, ldE, ldM, lu, br, jp, dst, anyStall, pipeStall;
        @(negedge clk);
        e = '0;
        mFlush = 0;
        if (resetn) begin
            ldE = hif.mem_to_reg_e || hif.cp0_to_reg_e;
            ldM = hif.mem_to_reg_m || hif.cp0_to_reg_m;
            lu = ldE && (hit(hif.rs_d, hif.rt_e, hif.wen_e) || hit(hif.rt_d, hif.rt_e, hif.wen_e));
            br = hif.branch_d && (hit(hif.rs_d, hif.wreg_e, hif.wen_e) || hit(hif.rt_d, hif.wreg_e, hif.wen_e)
                 || (ldM && (hit(hif.rs_d, hif.wreg_m, hif.wen_m) || hit(hif.rt_d, hif.wreg_m, hif.wen_m))));
            jp = hif.jump_d && (hit(hif.rs_d, hif.wreg_e, hif.wen_e) || (ldM && hit(hif.rs_d, hif.wreg_m, hif.wen_m)));
            dst = lu || br || jp;
            bst = hif.inst_busy || hif.data_busy;
            divSt = (mRem > 0) || (mRem == 0 && !mDone && hif.div_start_e);
            mFlush = (hif.exc_m || mPend) && !bst;
            e[16:15] = fwdE(hif.rs_e);
            e[14:13] = fwdE(hif.rt_e);
            e[12] = hit(hif.rs_d, hif.wreg_m, hif.wen_m);
            e[11] = hit(hif.rt_d, hif.wreg_m, hif.wen_m);
            e[10] = hif.hilo_read_e && hif.hilo_wen_m;
            e[0] = mDone;
            if (mFlush) begin
                e[4:1] = 4'hF;
            end else begin
                pipeStall = divSt || bst || mPend;
                anyStall = dst || pipeStall;
                e[9:5] = {anyStall, anyStall, pipeStall, pipeStall, pipeStall};
                e[3] = dst && !bst && !divSt;
            end
        end
        checkVal("model", 32'(outVec()), 32'(e));
    endtask

    // Advance the model across the next rising edge with the inputs currently applied.
    task automatic advance();
        if (!resetn) begin
            mRem = 0; mDone = 0; mPend = 0;
        end else if (mFlush) begin
            mRem = 0; mDone = 0; mPend = 0;
        end else begin
            if (hif.exc_m && (hif.inst_busy || hif.data_busy)) mPend = 1;
            if (mDone) begin
                mDone = 0;
            end else if (mRem > 0) begin
                if (!(hif.inst_busy || hif.data_busy)) begin
                    mRem--;
                    if (mRem == 0) mDone = 1;
                end
            end else if (hif.div_start_e) begin
                mRem = DIV_CYCLES - 2;
                if (mRem == 0) mDone = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    initial begin
        int stallCnt;
        int doneAt;

        clearInputs();
        resetn = 1'b0;
        settle();
        checkVal("rst_out", 32'(outVec()), 32'd0);
        advance();
        cycle();
        resetn = 1'b1;
        cycle();

        // forwarding priority and register zero
        hif.rs_e = 3; hif.wreg_m = 3; hif.wen_m = 1; hif.wreg_w = 3; hif.wen_w = 1;
        settle(); checkVal("t1_fwd_m", 32'(hif.fwd_a_e), 32'd2); advance();
        hif.wen_m = 0;
        settle(); checkVal("t1_fwd_w", 32'(hif.fwd_a_e), 32'd1); advance();
        hif.rs_e = 0;
        settle(); checkVal("t1_fwd_none", 32'(hif.fwd_a_e), 32'd0); advance();
        clearInputs(); cycle();

        // load-use bubble
        hif.wen_e = 1; hif.mem_to_reg_e = 1; hif.rt_e = 5; hif.rs_d = 5;
        settle();
        checkVal("t2_stall_fd", 32'({hif.stall_f, hif.stall_d}), 32'd3);
        checkVal("t2_flush_e", 32'(hif.flush_e), 32'd1);
        advance();
        hif.wen_e = 0; hif.mem_to_reg_e = 0;
        settle();
        checkVal("t2_clear", 32'({hif.stall_f, hif.stall_d, hif.flush_e}), 32'd0);
        advance();
        clearInputs(); cycle();

        // divide occupancy with start held through done
        hif.div_start_e = 1;
        stallCnt = 0; doneAt = 0;
        for (int c = 1; c <= 45 && doneAt == 0; c++) begin
            settle();
            if (hif.stall_e) stallCnt++;
            if (hif.div_done) doneAt = c;
            advance();
        end
        checkVal("t3_stall_cycles", 32'(stallCnt), 32'd33);
        checkVal("t3_done_cycle", 32'(doneAt), 32'd34);
        hif.div_start_e = 0;
        settle();
        checkVal("t3_no_restart", 32'({hif.stall_e, hif.div_done}), 32'd0);
        advance();
        clearInputs(); cycle();

        // bus stall freezes the divider
        hif.div_start_e = 1;
        doneAt = 0;
        for (int c = 1; c <= 50 && doneAt == 0; c++) begin
            hif.inst_busy = (c >= 10 && c <= 13);
            settle();
            if (hif.div_done) doneAt = c;
            advance();
        end
        checkVal("t4_done_cycle", 32'(doneAt), 32'd38);
        clearInputs(); cycle();

        // exception deferred behind an outstanding data transfer
        hif.div_start_e = 1;
        for (int c = 0; c < 5; c++) cycle();
        hif.exc_m = 1; hif.data_busy = 1;
        for (int c = 0; c < 3; c++) begin
            settle();
            checkVal("t5_no_flush", 32'({hif.flush_d, hif.flush_e, hif.flush_m, hif.flush_w}), 32'd0);
            advance();
        end
        hif.exc_m = 0; hif.data_busy = 0;
        settle();
        checkVal("t5_flush", 32'({hif.flush_d, hif.flush_e, hif.flush_m, hif.flush_w}), 32'hF);
        checkVal("t5_stall_override", 32'(hif.stall_e), 32'd0);
        advance();
        hif.div_start_e = 0;
        settle();
        checkVal("t5_div_idle", 32'({hif.stall_e, hif.div_done, hif.flush_d}), 32'd0);
        advance();
        clearInputs(); cycle();

        // reset with divider busy and flush pending
        hif.div_start_e = 1;
        for (int c = 0; c < 3; c++) cycle();
        hif.exc_m = 1; hif.data_busy = 1;
        cycle();
        hif.exc_m = 0;
        resetn = 1'b0;
        settle();
        checkVal("t6_rst_out", 32'(outVec()), 32'd0);
        advance();
        resetn = 1'b1;
        clearInputs();
        settle();
        checkVal("t6_no_stale", 32'({hif.flush_d, hif.flush_e, hif.div_done, hif.stall_e}), 32'd0);
        advance();
        settle();
        checkVal("t6_no_stale2", 32'({hif.flush_d, hif.div_done}), 32'd0);
        advance();

        // random traffic
        for (int c = 0; c < 800; c++) begin
            hif.rs_d = 5'($urandom_range(0, 3)); hif.rt_d = 5'($urandom_range(0, 3));
            hif.rs_e = 5'($urandom_range(0, 3)); hif.rt_e = 5'($urandom_range(0, 3));
            hif.wreg_e = 5'($urandom_range(0, 3)); hif.wreg_m = 5'($urandom_range(0, 3));
            hif.wreg_w = 5'($urandom_range(0, 3));
            hif.wen_e = 1'($urandom); hif.wen_m = 1'($urandom); hif.wen_w = 1'($urandom);
            hif.mem_to_reg_e = ($urandom_range(0, 3) == 0); hif.mem_to_reg_m = ($urandom_range(0, 3) == 0);
            hif.cp0_to_reg_e = ($urandom_range(0, 7) == 0); hif.cp0_to_reg_m = ($urandom_range(0, 7) == 0);
            hif.branch_d = ($urandom_range(0, 3) == 0); hif.jump_d = ($urandom_range(0, 5) == 0);
            hif.hilo_read_e = 1'($urandom); hif.hilo_wen_m = 1'($urandom);
            hif.div_start_e = ($urandom_range(0, 5) == 0);
            hif.inst_busy = ($urandom_range(0, 4) == 0); hif.data_busy = ($urandom_range(0, 4) == 0);
            hif.exc_m = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
